part_2_vec_stager: RTL and testbench

Receive-side staging buffer for the part_2 target co-simulation bridge, on the utility clock `clk_i`. Accepts per-channel 9-bit payloads ({wen, data}) from the fringe-get side, queues them per channel and applies one vector per channel to the DUT input ports on each mission-clock edge. It also captures the DUT upload vector. When a channel has no data at a mission edge, it raises that channel's freeze request and runs a watchdog.

---
 rtl/part_2_cs_pkg.sv | 15 +
 rtl/part_2_ch_fifo.sv | 43 ++++
 rtl/part_2_vec_stager.sv | 145 ++++++++++++++
 tb/tb_part_2_vec_stager.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/part_2_cs_pkg.sv
// Shared types and constants for the part_2 co-simulation bridge.
package part_2_cs_pkg;

  localparam int unsigned N_CH_C = 3;
  localparam int unsigned PW_C   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ERROR = 2'd2
  } stager_state_e;

  typedef logic [PW_C-1:0] payload_t;

endpackage

// File: rtl/part_2_ch_fifo.sv
// Per-channel payload FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB comparison.
module part_2_ch_fifo #(
  parameter int unsigned PW    = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [PW-1:0] din_i,
  output logic [PW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q, rptr_q;
  logic [PW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/part_2_vec_stager.sv
// Receive-side staging buffer: per-channel FIFOs drained one vector per mission
// edge, with upload capture, per-channel freeze requests and a stall watchdog.
module part_2_vec_stager
  import part_2_cs_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_C,
  parameter int unsigned PW       = PW_C,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WDOG_MAX = 10000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               rx_valid_i,
  input  logic [1:0]         rx_ch_i,
  input  logic [PW-1:0]      rx_data_i,
  output logic               rx_ready_o,
  output logic [N_CH*PW-1:0] dut_vec_o,
  output logic               dut_upd_o,
  input  logic               up_valid_i,
  input  logic [7:0]         up_data_i,
  output logic [PW-1:0]      up_vec_o,
  output logic               up_vld_o,
  output logic [N_CH-1:0]    freeze_o,
  output logic               wdog_err_o,
  output logic               tick_ovf_o
);

  localparam int unsigned WW = $clog2(WDOG_MAX + 1);

  stager_state_e      state_q, state_d;
  logic [WW-1:0]      wdog_q, wdog_d, wdog_cnt;
  logic [N_CH-1:0]    freeze_q, freeze_d;
  logic [2:0]         tick_sync_q;
  logic               tick_edge;
  logic [N_CH-1:0]    push, full, empty;
  logic               pop_all, all_avail;
  logic [PW-1:0]      dout [N_CH];
  logic [N_CH*PW-1:0] dut_vec_q;
  logic [PW-1:0]      up_vec_q;
  logic               dut_upd_q, up_vld_q, wdog_err_q, tick_ovf_q;

  // Two synchroniser flops plus one history flop for the rising-edge detect.
  assign tick_edge = tick_sync_q[1] & ~tick_sync_q[2];
  assign all_avail = ~|empty;

  always_comb begin
    rx_ready_o = 1'b1;
    push       = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (rx_ch_i == 2'(i)) begin
        rx_ready_o = ~full[i];
        push[i]    = rx_valid_i & ~full[i];
      end
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    part_2_ch_fifo #(
      .PW    (PW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[g]),
      .pop_i   (pop_all),
      .din_i   (rx_data_i),
      .dout_o  (dout[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    wdog_d   = wdog_q;
    freeze_d = freeze_q;
    pop_all  = 1'b0;
    wdog_cnt = wdog_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (tick_edge) begin
          if (all_avail) begin
            pop_all = 1'b1;
          end else begin
            state_d  = STALL;
            wdog_d   = '0;
            freeze_d = empty;
          end
        end
      end
      STALL: begin
        wdog_d   = wdog_cnt;
        freeze_d = empty;
        if (all_avail) begin
          pop_all  = 1'b1;
          freeze_d = '0;
          state_d  = IDLE;
        end else if (wdog_cnt == WW'(WDOG_MAX)) begin
          state_d = ERROR;
        end
      end
      ERROR:   freeze_d = '1;
      default: state_d  = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      freeze_q    <= '0;
      tick_sync_q <= '0;
      dut_vec_q   <= '0;
      dut_upd_q   <= 1'b0;
      up_vec_q    <= '0;
      up_vld_q    <= 1'b0;
      wdog_err_q  <= 1'b0;
      tick_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      freeze_q    <= freeze_d;
      tick_sync_q <= {tick_sync_q[1:0], tick_i};
      dut_upd_q   <= pop_all;
      if (pop_all) begin
        for (int i = 0; i < int'(N_CH); i++) dut_vec_q[i*PW +: PW] <= dout[i];
      end
      // Upload is sampled on every edge, even one that a stall drops.
      up_vld_q <= tick_edge && (state_q != ERROR);
      if (tick_edge && (state_q != ERROR)) up_vec_q <= PW'({up_valid_i, up_data_i});
      if (state_q == ERROR) wdog_err_q <= 1'b1;
      if (tick_edge && (state_q != IDLE)) tick_ovf_q <= 1'b1;
    end
  end

  assign dut_vec_o  = dut_vec_q;
  assign dut_upd_o  = dut_upd_q;
  assign up_vec_o   = up_vec_q;
  assign up_vld_o   = up_vld_q;
  assign freeze_o   = freeze_q;
  assign wdog_err_o = wdog_err_q;
  assign tick_ovf_o = tick_ovf_q;

endmodule

// File: tb/tb_part_2_vec_stager.sv
// Self-checking bench for part_2_vec_stager: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_part_2_vec_stager;

  localparam int N     = 3;
  localparam int PW    = 9;
  localparam int DEPTH = 4;
  localparam int WDOG  = 20;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            tick_i = 1'b0;
  logic            rx_valid_i = 1'b0;
  logic [1:0]      rx_ch_i = '0;
  logic [PW-1:0]   rx_data_i = '0;
  logic            rx_ready_o;
  logic [N*PW-1:0] dut_vec_o;
  logic            dut_upd_o;
  logic            up_valid_i = 1'b0;
  logic [7:0]      up_data_i = '0;
  logic [PW-1:0]   up_vec_o;
  logic            up_vld_o;
  logic [N-1:0]    freeze_o;
  logic            wdog_err_o;
  logic            tick_ovf_o;

  part_2_vec_stager #(
    .N_CH     (N),
    .PW       (PW),
    .DEPTH    (DEPTH),
    .WDOG_MAX (WDOG)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tick_i     (tick_i),
    .rx_valid_i (rx_valid_i),
    .rx_ch_i    (rx_ch_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o),
    .dut_vec_o  (dut_vec_o),
    .dut_upd_o  (dut_upd_o),
    .up_valid_i (up_valid_i),
    .up_data_i  (up_data_i),
    .up_vec_o   (up_vec_o),
    .up_vld_o   (up_vld_o),
    .freeze_o   (freeze_o),
    .wdog_err_o (wdog_err_o),
    .tick_ovf_o (tick_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue per channel and a mode (0 running, 1 waiting for
  // data, 2 halted) advanced once per clock from the inputs seen at that edge.
  logic [PW-1:0]   mq [N][$];
  int              mMode, mStallCycles;
  logic            mS1, mS2, mS3;
  logic [N*PW-1:0] mVec;
  logic [PW-1:0]   mUpVec;
  logic [N-1:0]    mFreeze;
  logic            mUpd, mUpVld, mErr, mOvf;

  always @(posedge clk_i or negedge rst_ni) begin : modelStep
    bit           tickEdge, allHave, pushOk;
    logic [N-1:0] emptyNow;
    int           prevMode, ch;
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mMode = 0; mStallCycles = 0;
      mS1 = 1'b0; mS2 = 1'b0; mS3 = 1'b0;
      mVec = '0; mUpVec = '0; mFreeze = '0;
      mUpd = 1'b0; mUpVld = 1'b0; mErr = 1'b0; mOvf = 1'b0;
    end else begin
      tickEdge = mS2 && !mS3;
      mS3 = mS2; mS2 = mS1; mS1 = tick_i;
      for (int i = 0; i < N; i++) emptyNow[i] = (mq[i].size() == 0);
      allHave  = (emptyNow == '0);
      ch       = int'(rx_ch_i);
      pushOk   = rx_valid_i && (ch < N) && (mq[ch].size() < DEPTH);
      prevMode = mMode;
      mUpd     = 1'b0;
      mUpVld   = 1'b0;
      if (tickEdge && prevMode != 0) mOvf = 1'b1;
      if (tickEdge && prevMode != 2) begin
        mUpVec = {up_valid_i, up_data_i};
        mUpVld = 1'b1;
      end
      if (prevMode == 2) begin
        mErr    = 1'b1;
        mFreeze = '1;
      end else if (prevMode == 1 || tickEdge) begin
        if (allHave) begin
          for (int i = 0; i < N; i++) mVec[i*PW +: PW] = mq[i].pop_front();
          mUpd    = 1'b1;
          mFreeze = '0;
          mMode   = 0;
        end else begin
          mStallCycles = (prevMode == 0) ? 0 : mStallCycles + 1;
          mFreeze      = emptyNow;
          mMode        = 1;
          if (prevMode == 1 && mStallCycles == WDOG) mMode = 2;
        end
      end
      if (pushOk) mq[ch].push_back(rx_data_i);
    end
  end

  always @(negedge clk_i) begin
    if (checkEn) begin
      int  ch;
      logic expRdy;
      ch     = int'(rx_ch_i);
      expRdy = (ch >= N) ? 1'b1 : (mq[ch].size() < DEPTH);
      checkOutput("model_dut_vec", 32'(dut_vec_o), 32'(mVec));
      checkOutput("model_dut_upd", 32'(dut_upd_o), 32'(mUpd));
      checkOutput("model_up_vec", 32'(up_vec_o), 32'(mUpVec));
      checkOutput("model_up_vld", 32'(up_vld_o), 32'(mUpVld));
      checkOutput("model_freeze", 32'(freeze_o), 32'(mFreeze));
      checkOutput("model_wdog_err", 32'(wdog_err_o), 32'(mErr));
      checkOutput("model_tick_ovf", 32'(tick_ovf_o), 32'(mOvf));
      checkOutput("model_rx_ready", 32'(rx_ready_o), 32'(expRdy));
    end
  end

  // One cycle of stimulus: drive just after a rising edge, return just after the next.
  task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [PW-1:0] d,
                               input logic tk, input logic uv, input logic [7:0] ud);
    rx_valid_i = v;
    rx_ch_i    = ch;
    rx_data_i  = d;
    tick_i     = tk;
    up_valid_i = uv;
    up_data_i  = ud;
    @(posedge clk_i);
    #1;
  endtask

  task automatic tickRun(input int cycles, output int firstUpd, output logic [N*PW-1:0] vecAt,
                         output logic [N-1:0] freezeAt3, output logic rdyAt, output int firstUpVld);
    firstUpd = 0; firstUpVld = 0; vecAt = '0; freezeAt3 = '0; rdyAt = 1'b0;
    for (int n = 1; n <= cycles; n++) begin
      applyStimulus(1'b0, 2'd1, '0, (n <= 3), 1'b1, 8'h3C);
      if (n == 3) freezeAt3 = freeze_o;
      if (dut_upd_o && firstUpd == 0) begin
        firstUpd = n;
        vecAt    = dut_vec_o;
        rdyAt    = rx_ready_o;
      end
      if (up_vld_o && firstUpVld == 0) firstUpVld = n;
    end
  endtask

  initial begin
    int              fu, fv, errN;
    logic [N*PW-1:0] va;
    logic [N-1:0]    fz;
    logic            rd;
    int              tickHold;
    logic            tickLvl;

    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkEn = 1'b1;
    checkOutput("reset_dut_vec", 32'(dut_vec_o), 32'h0);
    checkOutput("reset_freeze", 32'(freeze_o), 32'h0);
    checkOutput("reset_wdog_err", 32'(wdog_err_o), 32'h0);
    checkOutput("reset_up_vec", 32'(up_vec_o), 32'h0);
    rst_ni = 1'b1;
    applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 8'h00);

    $display("[TB] basic vector transfer and upload capture");
    applyStimulus(1'b1, 2'd0, 9'h1A5, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd1, 9'h0FF, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd2, 9'h100, 1'b0, 1'b0, 8'h00);
    tickRun(8, fu, va, fz, rd, fv);
    checkOutput("t1_upd_latency", 32'(fu), 32'd3);
    checkOutput("t1_vec", 32'(va), 32'({9'h100, 9'h0FF, 9'h1A5}));
    checkOutput("t1_upvld_latency", 32'(fv), 32'd3);
    checkOutput("t1_up_vec", 32'(up_vec_o), 32'h13C);
    checkOutput("t1_freeze", 32'(freeze_o), 32'h0);

    $display("[TB] stall on ch1 then release");
    applyStimulus(1'b1, 2'd0, 9'h011, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd2, 9'h022, 1'b0, 1'b0, 8'h00);
    tickRun(6, fu, va, fz, rd, fv);
    checkOutput("t2_freeze", 32'(fz), 32'b010);
    checkOutput("t2_no_upd", 32'(fu), 32'd0);
    applyStimulus(1'b1, 2'd1, 9'h055, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_upd_push_cycle", 32'(dut_upd_o), 32'h0);
    applyStimulus(1'b0, 2'd1, '0, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_upd_release", 32'(dut_upd_o), 32'h1);
    checkOutput("t2_freeze_release", 32'(freeze_o), 32'h0);
    checkOutput("t2_vec", 32'(dut_vec_o), 32'({9'h022, 9'h055, 9'h011}));

    $display("[TB] fill ch1 past depth");
    for (int k = 0; k < DEPTH + 1; k++) begin
      applyStimulus(1'b1, 2'd1, 9'(9'h0A0 + k), 1'b0, 1'b0, 8'h00);
      if (k == DEPTH - 2) checkOutput("t3_ready_before_full", 32'(rx_ready_o), 32'h1);
      if (k == DEPTH - 1) checkOutput("t3_ready_full", 32'(rx_ready_o), 32'h0);
    end
    applyStimulus(1'b1, 2'd0, 9'h0B0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd0, 9'h0B1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd2, 9'h0C0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd2, 9'h0C1, 1'b0, 1'b0, 8'h00);
    tickRun(6, fu, va, fz, rd, fv);
    checkOutput("t3_ready_after_pop", 32'(rd), 32'h1);
    checkOutput("t3_vec_first", 32'(va), 32'({9'h0C0, 9'h0A0, 9'h0B0}));
    tickRun(6, fu, va, fz, rd, fv);
    checkOutput("t3_vec_second", 32'(va), 32'({9'h0C1, 9'h0A1, 9'h0B1}));

    applyStimulus(1'b1, 2'd3, 9'h1FF, 1'b0, 1'b0, 8'h00);
    checkOutput("t4_ready_out_of_range", 32'(rx_ready_o), 32'h1);

    $display("[TB] reset during stall");
    tickRun(5, fu, va, fz, rd, fv);
    checkOutput("t5_freeze_stall", 32'(fz), 32'b101);
    rst_ni = 1'b0;
    #2;
    checkOutput("t5_rst_vec", 32'(dut_vec_o), 32'h0);
    checkOutput("t5_rst_freeze", 32'(freeze_o), 32'h0);
    checkOutput("t5_rst_up_vec", 32'(up_vec_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    applyStimulus(1'b0, 2'd1, '0, 1'b0, 1'b0, 8'h00);

    $display("[TB] watchdog");
    errN = 0;
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(1'b0, 2'd1, '0, (n <= 3), 1'b0, 8'h00);
      if (n == 3) checkOutput("t6_freeze_all_empty", 32'(freeze_o), 32'b111);
      if (wdog_err_o && errN == 0) errN = n;
    end
    checkOutput("t6_wdog_latency", 32'(errN), 32'd24);
    checkOutput("t6_freeze_error", 32'(freeze_o), 32'b111);
    tickRun(6, fu, va, fz, rd, fv);
    checkOutput("t6_tick_ovf", 32'(tick_ovf_o), 32'h1);

    $display("[TB] randomized traffic");
    tickLvl  = 1'b0;
    tickHold = 1;
    for (int seg = 0; seg < 10; seg++) begin
      rst_ni = 1'b0;
      applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 8'h00);
      rst_ni  = 1'b1;
      tickLvl = 1'b0;
      for (int c = 0; c < 250; c++) begin
        if (tickHold == 0) begin
          tickLvl  = ~tickLvl;
          tickHold = $urandom_range(1, 5);
        end
        tickHold--;
        applyStimulus(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 9'($urandom),
                      tickLvl, 1'($urandom), 8'($urandom));
      end
    end

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
